inc_pulse_gen: RTL and testbench

//   Conditions a raw, asynchronous, bouncing push-button into the single-cycle 'inc' strobe

---
 rtl/inc_pulse_gen.sv | 140 ++++++++++++++
 tb/tb_inc_pulse_gen.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inc_pulse_gen.sv
// Push-button conditioner: 2-flop synchronizer, debouncer and press/auto-repeat FSM
// turning a raw bouncing button into single-cycle inc strobes.
module inc_pulse_gen #(
    parameter int DB_CYCLES     = 4,
    parameter int HOLD_CYCLES   = 16,
    parameter int REPEAT_CYCLES = 8,
    parameter bit REPEAT_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    input  logic       enable,
    output logic       inc,
    output logic       btn_state,
    output logic [1:0] fsm_state
);

    localparam int DB_W    = $clog2(DB_CYCLES + 1);
    localparam int TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic             sync_meta;
    logic             sync_q;
    logic [DB_W-1:0]  db_cnt;
    logic             btn_state_d;
    logic             rise;
    state_t           state;
    state_t           state_nxt;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_nxt;
    logic             inc_nxt;
    logic             hold_done;
    logic             rep_done;

    // NOTE: non-blocking so each flop captures the pre-edge value; blocking would collapse the chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= btn_in;
            sync_q    <= sync_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt      <= '0;
            btn_state   <= 1'b0;
            btn_state_d <= 1'b0;
        end else begin
            btn_state_d <= btn_state;
            if (sync_q != btn_state) begin
                if (db_cnt == DB_LAST) begin
                    btn_state <= sync_q;
                    db_cnt    <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign rise      = btn_state & ~btn_state_d;
    assign hold_done = (timer == HOLD_LAST);
    assign rep_done  = (timer == REP_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            timer <= '0;
            inc   <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            inc   <= inc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (rise) state_nxt = PRESS;
                PRESS: begin
                    if (!btn_state)                  state_nxt = IDLE;
                    else if (hold_done && REPEAT_EN) state_nxt = REPEAT;
                end
                REPEAT:  if (!btn_state) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        inc_nxt   = 1'b0;
        timer_nxt = '0;
        if (enable) begin
            case (state)
                IDLE: inc_nxt = rise;
                PRESS: begin
                    if (btn_state) begin
                        if (hold_done) begin
                            // Without auto-repeat the timer parks at its last value.
                            inc_nxt   = REPEAT_EN;
                            timer_nxt = REPEAT_EN ? '0 : timer;
                        end else begin
                            timer_nxt = timer + TMR_W'(1);
                        end
                    end
                end
                REPEAT: begin
                    if (btn_state) begin
                        if (rep_done) inc_nxt = 1'b1;
                        else          timer_nxt = timer + TMR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_inc_pulse_gen.sv
// Self-checking bench for inc_pulse_gen: two instances (auto-repeat on/off) compared
// cycle by cycle against a window/arithmetic reference model, plus scenario checks.
module tb_inc_pulse_gen;

    localparam int DB   = 4;
    localparam int HOLD = 16;
    localparam int REP  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_in = 1'b0;
    logic       enable = 1'b1;
    logic       inc_a, bs_a, inc_b, bs_b;
    logic [1:0] fs_a, fs_b;
    logic [7:0] count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inc_pulse_gen #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .btn_in(btn_in), .enable(enable),
        .inc(inc_a), .btn_state(bs_a), .fsm_state(fs_a)
    );

    inc_pulse_gen #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .btn_in(btn_in), .enable(enable),
        .inc(inc_b), .btn_state(bs_b), .fsm_state(fs_b)
    );

    // 8-bit counter driven by the strobe for the integration scenario
    always @(posedge clk or negedge rst) begin
        if (!rst)       count <= 8'h00;
        else if (inc_a) count <= count + 8'h01;
    end

    // Reference model: level flips once the last DB synchronized samples all disagree;
    // pulse times are pure arithmetic on the distance from the first pulse.
    int         cyc = 0;
    logic       m_s1 = 1'b0, m_s2 = 1'b0, m_lvl = 1'b0, m_lvl_d = 1'b0;
    logic       win[$];
    bit         m_act[2];
    int         m_p[2];
    logic       m_inc[2];
    logic [1:0] m_fsm[2];

    always @(posedge clk or negedge rst) begin
        bit m_rise, all_diff, rep;
        int d;
        if (!rst) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0; m_lvl_d = 1'b0;
            win.delete();
            for (int i = 0; i < 2; i++) begin
                m_act[i] = 1'b0; m_p[i] = 0; m_inc[i] = 1'b0; m_fsm[i] = 2'd0;
            end
        end else begin
            cyc++;
            m_rise = m_lvl && !m_lvl_d;
            for (int i = 0; i < 2; i++) begin
                rep = (i == 0);
                m_inc[i] = 1'b0;
                if (!enable) begin
                    m_act[i] = 1'b0;
                end else if (m_act[i] && !m_lvl) begin
                    m_act[i] = 1'b0;
                end else if (!m_act[i] && m_rise) begin
                    m_act[i] = 1'b1;
                    m_p[i]   = cyc;
                    m_inc[i] = 1'b1;
                end else if (m_act[i]) begin
                    d = cyc - m_p[i];
                    m_inc[i] = rep && d >= HOLD && ((d - HOLD) % REP) == 0;
                end
                m_fsm[i] = !m_act[i] ? 2'd0 : ((rep && (cyc - m_p[i]) >= HOLD) ? 2'd2 : 2'd1);
            end
            win.push_back(m_s2);
            if (win.size() > DB) void'(win.pop_front());
            m_lvl_d = m_lvl;
            if (win.size() == DB) begin
                all_diff = 1'b1;
                foreach (win[j]) if (win[j] == m_lvl) all_diff = 1'b0;
                if (all_diff) m_lvl = !m_lvl;
            end
            m_s2 = m_s1;
            m_s1 = btn_in;
        end
    end

    // Observation on the falling edge, away from the active edge
    int   mis_cnt = 0, pulses_a = 0, pulses_b = 0, pulses_m = 0, bs_hi = 0, bs_fall_cyc = -1;
    int   pq[$];
    logic bs_prev = 1'b0;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (inc_a !== m_inc[0] || fs_a !== m_fsm[0] || bs_a !== m_lvl ||
                inc_b !== m_inc[1] || fs_b !== m_fsm[1] || bs_b !== m_lvl)
                mis_cnt++;
            if (inc_a === 1'b1) begin
                pulses_a++;
                pq.push_back(cyc);
            end
            if (inc_b === 1'b1) pulses_b++;
            if (m_inc[0])       pulses_m++;
            if (bs_a === 1'b1)  bs_hi++;
            if (bs_prev === 1'b1 && bs_a === 1'b0) bs_fall_cyc = cyc;
        end
        bs_prev = bs_a;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        int m0;
        rst = 1'b0; btn_in = 1'b0; enable = 1'b1;
        tick(3);
        checks++;
        if ({inc_a, bs_a, fs_a, inc_b, bs_b, fs_b} !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 0", {inc_a, bs_a, fs_a, inc_b, bs_b, fs_b});
        end
        rst = 1'b1;
        m0 = mis_cnt;
        tick(10);
        checks++;
        if (pulses_a !== 0 || mis_cnt - m0 !== 0) begin
            failures++;
            $display("FAIL reset_idle: pulses %0d mismatches %0d expected 0/0", pulses_a, mis_cnt - m0);
        end
    endtask

    task automatic test_single_press();
        int p0, m0, q0, n, r, got;
        p0 = pulses_a; m0 = mis_cnt; q0 = pq.size();
        n = cyc + 1;
        btn_in = 1'b1; tick(12);
        r = cyc + 1;
        btn_in = 1'b0; tick(12);
        checks++;
        if (pulses_a - p0 !== 1) begin
            failures++;
            $display("FAIL single_count: got %0d expected 1", pulses_a - p0);
        end
        got = (pq.size() > q0) ? pq[q0] - n : -1;
        checks++;
        if (got !== DB + 2) begin
            failures++;
            $display("FAIL single_latency: got %0d expected %0d", got, DB + 2);
        end
        checks++;
        if (bs_fall_cyc - r !== DB + 1) begin
            failures++;
            $display("FAIL release_latency: got %0d expected %0d", bs_fall_cyc - r, DB + 1);
        end
        checks++;
        if (mis_cnt - m0 !== 0) begin
            failures++;
            $display("FAIL single_model: got %0d mismatching cycles expected 0", mis_cnt - m0);
        end
    endtask

    task automatic test_glitch();
        int p0, h0, m0;
        p0 = pulses_a; h0 = bs_hi; m0 = mis_cnt;
        btn_in = 1'b1; tick(DB - 1);
        btn_in = 1'b0; tick(12);
        checks++;
        if (bs_hi - h0 !== 0 || pulses_a - p0 !== 0) begin
            failures++;
            $display("FAIL glitch: btn_state high %0d cycles, %0d pulses, expected 0/0", bs_hi - h0, pulses_a - p0);
        end
        checks++;
        if (mis_cnt - m0 !== 0) begin
            failures++;
            $display("FAIL glitch_model: got %0d mismatching cycles expected 0", mis_cnt - m0);
        end
    endtask

    task automatic test_bounce_repeat();
        int p0, pb0, m0, q0, got;
        int exp_off[6] = '{0, 16, 24, 32, 40, 48};
        p0 = pulses_a; pb0 = pulses_b; m0 = mis_cnt; q0 = pq.size();
        btn_in = 1'b1; tick(1);
        btn_in = 1'b0; tick(1);
        btn_in = 1'b1; tick(1);
        btn_in = 1'b0; tick(1);
        btn_in = 1'b1; tick(51);
        btn_in = 1'b0; tick(14);
        checks++;
        if (pulses_a - p0 !== 6) begin
            failures++;
            $display("FAIL repeat_count: got %0d expected 6", pulses_a - p0);
        end
        for (int i = 0; i < 6; i++) begin
            got = (pq.size() > q0 + i) ? pq[q0 + i] - pq[q0] : -1;
            checks++;
            if (got !== exp_off[i]) begin
                failures++;
                $display("FAIL repeat_offset[%0d]: got %0d expected %0d", i, got, exp_off[i]);
            end
        end
        checks++;
        if (pulses_b - pb0 !== 1) begin
            failures++;
            $display("FAIL bounce_norepeat: got %0d expected 1", pulses_b - pb0);
        end
        checks++;
        if (mis_cnt - m0 !== 0) begin
            failures++;
            $display("FAIL bounce_model: got %0d mismatching cycles expected 0", mis_cnt - m0);
        end
    endtask

    task automatic test_no_repeat();
        int pb0, m0;
        pb0 = pulses_b; m0 = mis_cnt;
        btn_in = 1'b1; tick(50);
        btn_in = 1'b0; tick(12);
        checks++;
        if (pulses_b - pb0 !== 1) begin
            failures++;
            $display("FAIL no_repeat_count: got %0d expected 1", pulses_b - pb0);
        end
        checks++;
        if (mis_cnt - m0 !== 0) begin
            failures++;
            $display("FAIL no_repeat_model: got %0d mismatching cycles expected 0", mis_cnt - m0);
        end
    endtask

    task automatic test_enable();
        int p0, m0;
        p0 = pulses_a; m0 = mis_cnt;
        enable = 1'b0; btn_in = 1'b1; tick(15);
        enable = 1'b1; tick(20);
        btn_in = 1'b0; tick(12);
        checks++;
        if (pulses_a - p0 !== 0 || pulses_b !== pulses_b) begin
            failures++;
            $display("FAIL enable_held: got %0d pulses expected 0", pulses_a - p0);
        end
        p0 = pulses_a;
        btn_in = 1'b1; tick(10);
        btn_in = 1'b0; tick(12);
        checks++;
        if (pulses_a - p0 !== 1) begin
            failures++;
            $display("FAIL enable_repress: got %0d pulses expected 1", pulses_a - p0);
        end
        p0 = pulses_a;
        btn_in = 1'b1; tick(30);
        enable = 1'b0; tick(1);
        checks++;
        if (fs_a !== 2'd0 || inc_a !== 1'b0) begin
            failures++;
            $display("FAIL enable_drop: fsm %0d inc %0d expected 0/0", fs_a, inc_a);
        end
        tick(20);
        enable = 1'b1; tick(20);
        btn_in = 1'b0; tick(12);
        checks++;
        if (pulses_a - p0 !== 2) begin
            failures++;
            $display("FAIL enable_midhold: got %0d pulses expected 2", pulses_a - p0);
        end
        checks++;
        if (mis_cnt - m0 !== 0) begin
            failures++;
            $display("FAIL enable_model: got %0d mismatching cycles expected 0", mis_cnt - m0);
        end
    endtask

    task automatic test_reset_mid();
        int p0, m0, q0, n, got;
        btn_in = 1'b1; tick(DB + 2 + HOLD + 1);
        checks++;
        if (fs_a !== 2'd2 || inc_a !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_state: fsm %0d inc %0d expected 2/1", fs_a, inc_a);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (inc_a !== 1'b0 || bs_a !== 1'b0 || fs_a !== 2'd0) begin
            failures++;
            $display("FAIL reset_immediate: inc %0d btn_state %0d fsm %0d expected 0/0/0", inc_a, bs_a, fs_a);
        end
        tick(2);
        rst = 1'b1;
        p0 = pulses_a; m0 = mis_cnt; q0 = pq.size();
        n = cyc + 1;
        tick(12);
        btn_in = 1'b0; tick(12);
        checks++;
        if (pulses_a - p0 !== 1) begin
            failures++;
            $display("FAIL post_reset_count: got %0d expected 1", pulses_a - p0);
        end
        got = (pq.size() > q0) ? pq[q0] - n : -1;
        checks++;
        if (got !== DB + 2) begin
            failures++;
            $display("FAIL post_reset_latency: got %0d expected %0d", got, DB + 2);
        end
        checks++;
        if (mis_cnt - m0 !== 0) begin
            failures++;
            $display("FAIL reset_mid_model: got %0d mismatching cycles expected 0", mis_cnt - m0);
        end
    endtask

    task automatic test_random();
        int p0, pm0, m0, len;
        p0 = pulses_a; pm0 = pulses_m; m0 = mis_cnt;
        repeat (40) begin
            len = $urandom_range(1, 30);
            btn_in = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    btn_in = ~btn_in; tick(1);
                    btn_in = ~btn_in;
                end
                if ($urandom_range(0, 19) == 0) enable = ~enable;
                tick(1);
            end
        end
        enable = 1'b1; btn_in = 1'b0; tick(20);
        checks++;
        if (pulses_a - p0 !== pulses_m - pm0) begin
            failures++;
            $display("FAIL random_pulses: got %0d expected %0d", pulses_a - p0, pulses_m - pm0);
        end
        checks++;
        if (mis_cnt - m0 !== 0) begin
            failures++;
            $display("FAIL random_model: got %0d mismatching cycles expected 0", mis_cnt - m0);
        end
    endtask

    task automatic test_counter();
        rst = 1'b0; btn_in = 1'b0; enable = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(4);
        repeat (255) begin
            btn_in = 1'b1; tick(8);
            btn_in = 1'b0; tick(8);
        end
        tick(4);
        checks++;
        if (count !== 8'hFF) begin
            failures++;
            $display("FAIL counter_255: got %0h expected ff", count);
        end else begin
            $display("counter count=%0h PASS", count);
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_bounce_repeat();
        test_no_repeat();
        test_enable();
        test_reset_mid();
        test_random();
        test_counter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
